sram_fifo_arb: RTL and testbench

//  Parametrised FIFO controller over one external single-port SRAM; successor to the 12-bit fixed FIFO.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ptr.sv | 39 +++
 rtl/sram_fifo_arb.sv | 160 ++++++++++++++++
 tb/tb_sram_fifo_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, defaults and helpers for the SRAM-backed FIFO
package fifo_pkg;

  typedef enum logic {
    PRI_WRITE = 1'b0,
    PRI_READ  = 1'b1
  } fifo_pri_t;

  localparam int DEF_BUS_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_AF_THRESH  = 1020;
  localparam int DEF_AE_THRESH  = 4;

  localparam fifo_pri_t PRI_RST = PRI_WRITE;

  // Side that gets precedence after a contended grant has been handed out.
  function automatic fifo_pri_t pri_flip(input fifo_pri_t p);
    return (p == PRI_WRITE) ? PRI_READ : PRI_WRITE;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping SRAM address pointer with synchronous clear
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // Next pointer: flush to zero, otherwise advance; DEPTH-1 -> 0 wraps naturally.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_ONE;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sram_fifo_arb.sv
// rtl/sram_fifo_arb.sv - FIFO over one single-port SRAM, round-robin W/R arbitration (option FIFO_ERR_EN)
module sram_fifo_arb
  import fifo_pkg::*;
#(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  w_enable,
  input  logic [BUS_WIDTH-1:0]  data_i,
  output logic                  w_ready,
  input  logic                  r_enable,
  output logic                  r_ready,
  output logic [BUS_WIDTH-1:0]  data_o,
  output logic                  r_valid,
  input  logic [BUS_WIDTH-1:0]  sram_o,
  output logic [BUS_WIDTH-1:0]  sram_i,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_wen,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  fifo_pri_t             pri_q, pri_d;
  logic                  r_valid_q, r_valid_d;
  logic                  w_ok, r_ok, grant_w, grant_r;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (grant_w),
    .ptr_o (wptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (grant_r),
    .ptr_o (rptr)
  );

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  assign w_ok = w_enable & ~full;
  assign r_ok = r_enable & ~empty;

  // Grant arbitration and priority next-state; priority only moves when both sides contend.
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    pri_d   = pri_q;
    if (clear) begin
      pri_d = PRI_RST;
    end else if (w_ok && r_ok) begin
      if (pri_q == PRI_WRITE) begin
        grant_w = 1'b1;
      end else begin
        grant_r = 1'b1;
      end
      pri_d = pri_flip(pri_q);
    end else begin
      grant_w = w_ok;
      grant_r = r_ok;
    end
  end

  // Priority state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pri_q <= PRI_RST;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Occupancy and read-valid next state; grants are exclusive so +1 and -1 never coincide.
  always_comb begin
    count_d   = count_q;
    r_valid_d = grant_r;
    if (clear) begin
      count_d = '0;
    end else if (grant_w) begin
      count_d = count_q + CNT_ONE;
    end else if (grant_r) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Occupancy and read-valid registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign w_ready   = grant_w;
  assign r_ready   = grant_r;
  assign sram_wen  = grant_w;
  assign sram_ren  = grant_r;
  assign sram_i    = data_i;
  assign sram_addr = grant_w ? wptr : rptr;
  assign r_valid   = r_valid_q;
  assign data_o    = r_valid_q ? sram_o : '0;

`ifdef FIFO_ERR_EN
  logic ovf_q, unf_q;

  // Sticky error flags for requests refused because the FIFO was full or empty.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (w_enable && full) begin
        ovf_q <= 1'b1;
      end
      if (r_enable && empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_arb.sv
// tb/tb_sram_fifo_arb.sv - directed vector bench for sram_fifo_arb with an SRAM model
module tb_sram_fifo_arb;

`ifdef FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear, w_enable, r_enable;
  logic [7:0]  data_i, data_o, sram_o, sram_i;
  logic        w_ready, r_ready, r_valid, sram_wen, sram_ren;
  logic [9:0]  sram_addr;
  logic [10:0] count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_fifo_arb dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .w_enable     (w_enable),
    .data_i       (data_i),
    .w_ready      (w_ready),
    .r_enable     (r_enable),
    .r_ready      (r_ready),
    .data_o       (data_o),
    .r_valid      (r_valid),
    .sram_o       (sram_o),
    .sram_i       (sram_i),
    .sram_addr    (sram_addr),
    .sram_wen     (sram_wen),
    .sram_ren     (sram_ren),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // External single-port SRAM, one-cycle read latency.
  logic [7:0] mem [0:1023];
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_i;
    if (sram_ren) rd_q <= mem[sram_addr];
  end
  assign sram_o = rd_q;

  typedef struct {
    logic       c;
    logic       we;
    logic [7:0] d;
    logic       re;
    logic       ewr;
    logic       err;
    int         ecnt;
    logic       erv;
    logic [7:0] edo;
    int         ea;
    logic       euf;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mk(logic c, logic we, logic [7:0] d, logic re, logic ewr, logic err,
                              int ecnt, logic erv, logic [7:0] edo, int ea, logic euf);
    vec_t v;
    v.c = c; v.we = we; v.d = d; v.re = re; v.ewr = ewr; v.err = err;
    v.ecnt = ecnt; v.erv = erv; v.edo = edo; v.ea = ea; v.euf = euf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic we, input logic [7:0] d, input logic re);
    @(negedge clk);
    clear = c; w_enable = we; data_i = d; r_enable = re;
    #1;
  endtask

  int          wp, rp;
  logic [7:0]  q [$];
  logic [7:0]  exp_d;
  logic        pend;

  initial begin
    tbl[0]  = mk(0,0,8'h00,0, 0,0, 0, 0,8'h00, 0, 0);
    tbl[1]  = mk(0,1,8'hA1,0, 1,0, 0, 0,8'h00, 0, 0);
    tbl[2]  = mk(0,1,8'hB2,0, 1,0, 1, 0,8'h00, 1, 0);
    tbl[3]  = mk(0,1,8'hC3,0, 1,0, 2, 0,8'h00, 2, 0);
    tbl[4]  = mk(0,0,8'h00,1, 0,1, 3, 0,8'h00, 0, 0);
    tbl[5]  = mk(0,0,8'h00,1, 0,1, 2, 1,8'hA1, 1, 0);
    tbl[6]  = mk(0,0,8'h00,1, 0,1, 1, 1,8'hB2, 2, 0);
    tbl[7]  = mk(0,0,8'h00,0, 0,0, 0, 1,8'hC3, 3, 0);
    tbl[8]  = mk(0,0,8'h00,0, 0,0, 0, 0,8'h00, 3, 0);
    tbl[9]  = mk(0,0,8'h00,1, 0,0, 0, 0,8'h00, 3, 0);
    tbl[10] = mk(0,1,8'd10,0, 1,0, 0, 0,8'h00, 3, ERR);
    tbl[11] = mk(0,1,8'd11,0, 1,0, 1, 0,8'h00, 4, ERR);
    tbl[12] = mk(0,1,8'd12,0, 1,0, 2, 0,8'h00, 5, ERR);
    tbl[13] = mk(0,1,8'd13,0, 1,0, 3, 0,8'h00, 6, ERR);
    tbl[14] = mk(0,1,8'd14,0, 1,0, 4, 0,8'h00, 7, ERR);
    tbl[15] = mk(0,1,8'd15,1, 1,0, 5, 0,8'h00, 8, ERR);
    tbl[16] = mk(0,1,8'd16,1, 0,1, 6, 0,8'h00, 3, ERR);
    tbl[17] = mk(0,1,8'd17,1, 1,0, 5, 1,8'd10, 9, ERR);
    tbl[18] = mk(0,1,8'd18,1, 0,1, 6, 0,8'h00, 4, ERR);
    tbl[19] = mk(0,0,8'h00,0, 0,0, 5, 1,8'd11, 5, ERR);
    tbl[20] = mk(0,1,8'd20,1, 1,0, 5, 0,8'h00,10, ERR);
    tbl[21] = mk(0,1,8'd21,0, 1,0, 6, 0,8'h00,11, ERR);
    tbl[22] = mk(0,1,8'd22,0, 1,0, 7, 0,8'h00,12, ERR);
    tbl[23] = mk(0,0,8'h00,1, 0,1, 8, 0,8'h00, 5, ERR);
    tbl[24] = mk(1,1,8'd24,1, 0,0, 7, 1,8'd12, 6, ERR);
    tbl[25] = mk(0,0,8'h00,0, 0,0, 0, 0,8'h00, 0, 0);
    tbl[26] = mk(0,1,8'd26,0, 1,0, 0, 0,8'h00, 0, 0);
    tbl[27] = mk(0,1,8'd27,1, 1,0, 1, 0,8'h00, 1, 0);
    tbl[28] = mk(0,0,8'h00,1, 0,1, 2, 0,8'h00, 0, 0);
    tbl[29] = mk(0,0,8'h00,1, 0,1, 1, 1,8'd26, 1, 0);
    tbl[30] = mk(0,0,8'h00,0, 0,0, 0, 1,8'd27, 2, 0);

    n_rst = 1'b0; clear = 0; w_enable = 0; r_enable = 0; data_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_dout", data_o, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    n_rst = 1'b1;

    // Basic order, empty read, contention, clear with pending read, post-clear priority.
    for (int i = 0; i < 31; i++) begin
      step(tbl[i].c, tbl[i].we, tbl[i].d, tbl[i].re);
      chk($sformatf("v%0d_wready", i), w_ready, tbl[i].ewr);
      chk($sformatf("v%0d_rready", i), r_ready, tbl[i].err);
      chk($sformatf("v%0d_wen", i), sram_wen, tbl[i].ewr);
      chk($sformatf("v%0d_ren", i), sram_ren, tbl[i].err);
      chk($sformatf("v%0d_count", i), count, tbl[i].ecnt);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].ecnt == 0);
      chk($sformatf("v%0d_aempty", i), almost_empty, tbl[i].ecnt <= 4);
      chk($sformatf("v%0d_full", i), full, 0);
      chk($sformatf("v%0d_rvalid", i), r_valid, tbl[i].erv);
      chk($sformatf("v%0d_dout", i), data_o, tbl[i].edo);
      chk($sformatf("v%0d_addr", i), sram_addr, tbl[i].ea);
      chk($sformatf("v%0d_sram_i", i), sram_i, tbl[i].d);
      chk($sformatf("v%0d_unf", i), underflow, tbl[i].euf);
      chk($sformatf("v%0d_ovf", i), overflow, 0);
    end

    // Fill to full from pointer 2, then one refused write.
    wp = 2; rp = 2;
    for (int i = 0; i < 1024; i++) begin
      step(0, 1, 8'(i ^ 8'h5A), 0);
      chk("fill_wready", w_ready, 1);
      chk("fill_count", count, i);
      chk("fill_addr", sram_addr, wp);
      if (i == 4)    chk("ae_at4", almost_empty, 1);
      if (i == 5)    chk("ae_at5", almost_empty, 0);
      if (i == 1019) chk("af_at1019", almost_full, 0);
      if (i == 1020) chk("af_at1020", almost_full, 1);
      q.push_back(8'(i ^ 8'h5A));
      wp = (wp + 1) % 1024;
    end
    step(0, 1, 8'hEE, 0);
    chk("full_flag", full, 1);
    chk("full_wready", w_ready, 0);
    chk("full_wen", sram_wen, 0);
    chk("full_count", count, 1024);
    step(0, 0, 8'h00, 0);
    chk("full_count_hold", count, 1024);
    chk("ovf_set", overflow, ERR);

    // Drain in order across the pointer wrap.
    pend = 0;
    for (int i = 0; i < 1024; i++) begin
      step(0, 0, 8'h00, 1);
      chk("drain_rready", r_ready, 1);
      chk("drain_addr", sram_addr, rp);
      chk("drain_rvalid", r_valid, pend);
      if (pend) chk("drain_data", data_o, exp_d);
      exp_d = q.pop_front();
      pend = 1;
      rp = (rp + 1) % 1024;
    end
    step(0, 0, 8'h00, 0);
    chk("drain_last_rvalid", r_valid, 1);
    chk("drain_last_data", data_o, exp_d);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);

    // Streamed write/read pairs; both pointers wrap 1023 -> 0.
    wp = 0; rp = 0; pend = 0;
    for (int k = 0; k < 1030; k++) begin
      step(0, 1, 8'(k * 7 + 3), 0);
      chk("st_wready", w_ready, 1);
      chk("st_waddr", sram_addr, wp);
      chk("st_wcount", count, 0);
      chk("st_rvalid", r_valid, pend);
      if (pend) chk("st_data", data_o, exp_d);
      exp_d = 8'(k * 7 + 3);
      wp = (wp + 1) % 1024;
      step(0, 0, 8'h00, 1);
      chk("st_rready", r_ready, 1);
      chk("st_raddr", sram_addr, rp);
      chk("st_rcount", count, 1);
      rp = (rp + 1) % 1024;
      pend = 1;
    end
    step(0, 0, 8'h00, 0);
    chk("st_last_rvalid", r_valid, 1);
    chk("st_last_data", data_o, exp_d);
    chk("st_end_empty", empty, 1);
    chk("st_wrap_ptr", sram_addr, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
